// File: rtl/mem_responder.sv
// Memory-side responder for the LC-3b datapath memory port: accepts a held
// read/write request, inserts LATENCY-1 wait states, then pulses mem_resp.
module mem_responder #(
    parameter int LATENCY    = 3,
    parameter int INDEX_BITS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [15:0] mem_address,
    input  logic [15:0] mem_wdata,
    input  logic [1:0]  mem_byte_enable,
    output logic        mem_resp,
    output logic [15:0] mem_rdata,
    output logic        prot_err
);
    localparam int DEPTH = 1 << INDEX_BITS;

    typedef enum logic [1:0] {IDLE, WAIT, RESPOND} state_t;

    state_t                state, state_nxt;
    logic [3:0]            cnt, cnt_nxt;
    logic                  accept;
    logic                  req;
    logic [INDEX_BITS-1:0] idx;
    logic [15:0]           wdata_q;
    logic [1:0]            be_q;
    logic                  is_write;
    logic [15:0]           mem [DEPTH];

    // Address bits outside the word index are deliberately ignored (aliasing).
    logic unused_addr;
    assign unused_addr = ^{mem_address[15:INDEX_BITS+1], mem_address[0]};

    assign req = mem_read | mem_write;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        unique case (state)
            IDLE: begin
                if (req) begin
                    accept    = 1'b1;
                    cnt_nxt   = 4'(LATENCY - 1);
                    state_nxt = (LATENCY == 1) ? RESPOND : WAIT;
                end
            end
            WAIT: begin
                if (!req) begin
                    // Initiator dropped the request: abandon it silently.
                    state_nxt = IDLE;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                    if (cnt == 4'd1) state_nxt = RESPOND;
                end
            end
            RESPOND: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            prot_err <= 1'b0;
            idx      <= '0;
            wdata_q  <= 16'h0000;
            be_q     <= 2'b00;
            is_write <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                idx      <= mem_address[INDEX_BITS:1];
                wdata_q  <= mem_wdata;
                be_q     <= mem_byte_enable;
                // Read+write together resolves to a write and is flagged.
                is_write <= mem_write;
                if (mem_read && mem_write) prot_err <= 1'b1;
            end
        end
    end

    // Array is not reset; a reset forces IDLE so no pending write can land.
    always_ff @(posedge clk) begin
        if (state == RESPOND && is_write) begin
            if (be_q[0]) mem[idx][7:0]  <= wdata_q[7:0];
            if (be_q[1]) mem[idx][15:8] <= wdata_q[15:8];
        end
    end

    assign mem_resp  = (state == RESPOND);
    assign mem_rdata = (mem_resp && !is_write) ? mem[idx] : 16'h0000;

endmodule
